// File: rtl/ct_spsram_pkg.sv
// ct_spsram_pkg: shared FSM state type and address-width helper for ct_spsram_param.
package ct_spsram_pkg;
  typedef enum logic {ST_INIT, ST_RDY} state_e;
  function automatic int f_addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/ct_spsram_init_ctrl.sv
// ct_spsram_init_ctrl: post-reset clear sweep FSM; drives sweep writes and READY.
module ct_spsram_init_ctrl
  import ct_spsram_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_sweep_we,
  output logic [ADDR_WIDTH-1:0] o_sweep_addr,
  output logic                  o_ready
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_e                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == ST_INIT) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  always_comb w_next = (r_state == ST_INIT && r_cnt == LAST) ? ST_RDY : r_state;
  always_comb begin
    o_sweep_we   = r_state == ST_INIT;
    o_ready      = r_state == ST_RDY;
    o_sweep_addr = r_cnt;
  end
endmodule

// File: rtl/ct_spsram_param.sv
// ct_spsram_param: parametrised single-port SRAM with bit-mask writes, taint shadow and clear sweep.
// Define CT_SPSRAM_OUT_REG_EN to add a second output register stage (read latency 2).
module ct_spsram_param
  import ct_spsram_pkg::*;
#(
  parameter  int DEPTH      = 256,
  parameter  int DATA_WIDTH = 144,
  localparam int ADDR_WIDTH = f_addr_width(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  READY,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN_t0,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q_t0
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_shd [DEPTH];
  logic [DATA_WIDTH-1:0] r_q1, r_qt1, w_mask, w_din, w_tmask, w_tdin;
  logic [ADDR_WIDTH-1:0] w_sweep_addr, w_addr;
  logic                  w_sweep_we, w_ready, w_ext_we, w_rd, w_we, w_ctl_t;
  ct_spsram_init_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_init (
    .i_clk       (CLK),
    .i_rst       (RST),
    .o_sweep_we  (w_sweep_we),
    .o_sweep_addr(w_sweep_addr),
    .o_ready     (w_ready)
  );
  // Unwritten bits whose enable is tainted still pick up taint (tdin is 1 there).
  always_comb begin
    w_ctl_t  = (|A_t0) | CEN_t0 | GWEN_t0;
    w_ext_we = w_ready & ~RST & ~CEN & ~GWEN;
    w_rd     = w_ready & ~CEN & GWEN;
    w_we     = w_sweep_we | w_ext_we;
    w_addr   = w_sweep_we ? w_sweep_addr : A;
    w_mask   = w_sweep_we ? '1 : ~WEN;
    w_din    = w_sweep_we ? '0 : D;
    w_tmask  = w_sweep_we ? '1 : (~WEN | WEN_t0);
    w_tdin   = w_sweep_we ? '0 : (D_t0 | WEN_t0 | {DATA_WIDTH{w_ctl_t}});
  end
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_addr] <= (r_mem[w_addr] & ~w_mask) | (w_din & w_mask);
      r_shd[w_addr] <= (r_shd[w_addr] & ~w_tmask) | (w_tdin & w_tmask);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q1  <= '0;
      r_qt1 <= '0;
    end else if (w_rd) begin
      r_q1  <= r_mem[A];
      r_qt1 <= r_shd[A] | {DATA_WIDTH{w_ctl_t}};
    end
  end
`ifdef CT_SPSRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_q2, r_qt2;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q2  <= '0;
      r_qt2 <= '0;
    end else begin
      r_q2  <= r_q1;
      r_qt2 <= r_qt1;
    end
  end
  assign Q    = r_q2;
  assign Q_t0 = r_qt2;
`else
  assign Q    = r_q1;
  assign Q_t0 = r_qt1;
`endif
  assign READY = w_ready;
endmodule

// File: tb/tb_ct_spsram_param.sv
// tb_ct_spsram_param: directed self-checking bench for ct_spsram_param (DEPTH=16, DATA_WIDTH=16).
module tb_ct_spsram_param;
  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 4;
`ifdef CT_SPSRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic          CLK, RST, CEN, GWEN, READY, CEN_t0, GWEN_t0;
  logic [AW-1:0] A, A_t0;
  logic [DW-1:0] WEN, D, Q, WEN_t0, D_t0, Q_t0;
  int nchk = 0;
  int nerr = 0;
  ct_spsram_param #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(Q), .READY(READY), .A_t0(A_t0), .CEN_t0(CEN_t0), .GWEN_t0(GWEN_t0),
    .WEN_t0(WEN_t0), .D_t0(D_t0), .Q_t0(Q_t0)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0;
    A_t0 = '0; CEN_t0 = 1'b0; GWEN_t0 = 1'b0; WEN_t0 = '0; D_t0 = '0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen,
                    input logic [DW-1:0] dt, input logic [DW-1:0] wt);
    @(negedge CLK);
    A = a; D = d; WEN = wen; D_t0 = dt; WEN_t0 = wt; CEN = 1'b0; GWEN = 1'b0;
    @(posedge CLK); #1;
    idle();
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] at, input logic [DW-1:0] eq,
                    input logic [DW-1:0] et, input string tag);
    @(negedge CLK);
    A = a; A_t0 = at; CEN = 1'b0; GWEN = 1'b1;
    @(posedge CLK); #1;
    idle();
    repeat (LAT - 1) begin @(posedge CLK); #1; end
    check({tag, "_q"}, 32'(Q), 32'(eq));
    check({tag, "_qt"}, 32'(Q_t0), 32'(et));
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!READY && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (!READY) check({tag, "_q_init"}, 32'(Q), 32'h0);
    end
    check({tag, "_ready_cycles"}, 32'(n), 32'(DEPTH));
  endtask
  initial begin
    idle(); A = '0; RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_q", 32'(Q), 32'h0);
    check("rst_qt", 32'(Q_t0), 32'h0);
    check("rst_ready", 32'(READY), 32'h0);
    // release reset while hammering a write to A=9 that the sweep must ignore
    @(negedge CLK);
    RST = 1'b0; A = 4'd9; D = '1; WEN = '0; D_t0 = '1; CEN = 1'b0; GWEN = 1'b0;
    wait_ready("sweep1");
    idle();
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), '0, 16'h0, 16'h0, "clear");
    wr(4'd5, 16'hFFFF, 16'hFFF0, '0, '0);
    check("wr_hold_q", 32'(Q), 32'h0);
    rd(4'd5, '0, 16'h000F, 16'h0, "mask");
    wr(4'd6, 16'h5555, 16'h0000, '0, '0);
    check("wr_hold_q2", 32'(Q), 32'h000F);
    @(posedge CLK); #1;
    check("wr_hold_q3", 32'(Q), 32'h000F);
    rd(4'd6, '0, 16'h5555, 16'h0, "full");
    wr(4'd3, 16'h1234, 16'h0000, 16'h0001, '0);
    rd(4'd3, '0, 16'h1234, 16'h0001, "taint");
    rd(4'd3, 4'd1, 16'h1234, 16'hFFFF, "taint_a");
    wr(4'd5, 16'hFFFF, 16'hFFFF, '0, 16'h0100);
    rd(4'd5, '0, 16'h000F, 16'h0100, "taint_wen");
    wr(4'd7, 16'hABCD, 16'h0000, '0, '0);
    rd(4'd7, '0, 16'hABCD, 16'h0, "raw");
    repeat (3) @(posedge CLK);
    #1;
    check("idle_hold_q", 32'(Q), 32'hABCD);
    // reset, then restart the sweep again at count 7
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    check("mid_ready", 32'(READY), 32'h0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_ready", 32'(READY), 32'h0);
    check("mid_rst_q", 32'(Q), 32'h0);
    @(negedge CLK); RST = 1'b0;
    wait_ready("sweep2");
    rd(4'd3, '0, 16'h0, 16'h0, "post_rst");
    rd(4'd7, '0, 16'h0, 16'h0, "post_rst7");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ct_spsram_param.md
Name: ct_spsram_param

Overview:
- Parametrised single-port synchronous SRAM: the next generation of the fixed-size ct_spsram_NxM wrappers.
- Generic DEPTH and DATA_WIDTH, with an active-low per-bit write mask.
- Carries a real taint shadow array alongside the data array, so Q_t0 reflects actual stored and address taint instead of being tied to zero.
- Adds a post-reset clear sweep with a READY indication. Instantiated by cache/TLB arrays in place of fixed-size macros.

Parameters:
- DEPTH, 256, number of words; must be a power of two, >=2.
- DATA_WIDTH, 144, bits per word; also the write-mask width.
- ADDR_WIDTH, $clog2(DEPTH), derived localparam; not overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- A  in  ADDR_WIDTH  word address.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low.
- WEN  in  DATA_WIDTH  per-bit write enable, active low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- READY  out  1  high once the clear sweep is complete.
- A_t0, CEN_t0, GWEN_t0, WEN_t0, D_t0  in  same width as the respective port  taint of each input.
- Q_t0  out  DATA_WIDTH  taint of Q.

Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.

Behaviour:
- Reset (RST=1 at an edge):
  - Q=0, Q_t0=0, READY=0.
  - Sweep counter=0; FSM enters INIT.
  - Array contents are not reset directly; the sweep clears them.
- FSM INIT:
  - Each cycle writes data=0 and taint=0 to entry[cnt], then cnt++.
  - When cnt==DEPTH-1 is written, go to RDY next cycle; READY=1 from that cycle.
  - The sweep takes exactly DEPTH cycles.
  - All external accesses during INIT are ignored; Q and Q_t0 hold 0.
- FSM RDY: normal operation. Only RST leaves RDY. RST asserted mid-sweep or mid-access restarts the sweep at 0.
- Access decode in RDY:
  - CEN=1: idle; Q and Q_t0 hold.
  - CEN=0, GWEN=0 (write): for each bit i with WEN[i]=0, mem[A][i]<=D[i]. Q and Q_t0 hold (no write-through).
  - CEN=0, GWEN=1 (read): Q<=mem[A] at the next edge. Latency 1 cycle. Q holds until the next read.
- Taint on write, per written bit i: shadow[A][i] <= D_t0[i] | WEN_t0[i] | GWEN_t0 | CEN_t0 | (|A_t0).
  - Bits with WEN[i]=1 but WEN_t0[i]=1 also take shadow <= mem-old taint | 1, i.e. they become tainted.
- Taint on read: Q_t0 <= shadow[A] | {DATA_WIDTH{(|A_t0) | CEN_t0 | GWEN_t0}}.
- Boundaries:
  - Addresses wrap naturally; no out-of-range access exists, since DEPTH is a power of two.
  - Back-to-back read-after-write to the same address returns the new data one cycle after the read.
  - X-free requirement: Q is never driven from an unwritten entry after READY.

Optional Feature:
- Macro: CT_SPSRAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage for Q and Q_t0; read latency becomes 2 cycles.
  - The stage resets to 0 and updates every cycle with the first stage.
  - READY is unchanged.
- Undefined: latency 1 as above.

Decomposition:
- Package ct_spsram_pkg holds:
  - the FSM state enum (ST_INIT, ST_RDY);
  - the function computing ADDR_WIDTH.
- Sub-module ct_spsram_init_ctrl holds:
  - the FSM and sweep counter;
  - outputs sweep_we, sweep_addr and READY.
- The top level muxes sweep writes against external writes.

Test Plan:
- Clear sweep: DEPTH=16. Pulse RST 1 cycle, then read all addresses.
  - READY rises exactly 16 cycles after reset is released.
  - Every read returns Q=0, Q_t0=0.
- Masked write: write A=5, D=all-ones, WEN=0x...F0 (low 4 bits written), then read A=5.
  - Q=0x...0F one cycle after the read.
- Taint: write A=3 with D_t0 bit0=1, then read A=3.
  - Q_t0=0x1.
  - A second read with A_t0=1 returns Q_t0=all-ones.
- Access during INIT: issue a write during the sweep, then read after READY.
  - The entry reads 0; Q stays 0 throughout INIT.
- Reset mid-operation: assert RST at sweep count 7.
  - Counter restarts; READY rises DEPTH cycles after release.
- CT_SPSRAM_OUT_REG_EN defined: read A=5 after the masked-write test.
  - Q=0x...0F appears 2 cycles after the read.
  - Q holds its prior value during write cycles.
